// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor controller.
// One full-adder cell is reused across all WIDTH bits, LSB first, one bit per clock.
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   start            - operation request, sampled only while idle
//   Sub              - 0: A+B+Cin, 1: A-B (sampled with start)
//   A, B             - operands (sampled with start)
//   Cin              - carry-in for add, ignored for subtract (sampled with start)
//   busy             - high while bits are being processed
//   done             - one-cycle pulse when Sum/Cout/Ovf take a new result
//   Sum, Cout, Ovf   - registered result, carry-out (inverted borrow on subtract)
//                      and signed overflow

module full_adder_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_c,
   output logic co_c
);
   // Single-bit full adder shared by every bit position.
   assign s_c  = a_i ^ b_i ^ ci_i;
   assign co_c = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cmsb_q, cmsb_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic cell_s;
   logic cell_co;

   // The one shared adder cell always works on the current LSBs.
   full_adder_cell u_cell (
      .a_i  (opa_q[0]),
      .b_i  (opb_q[0]),
      .ci_i (carry_q),
      .s_c  (cell_s),
      .co_c (cell_co)
   );

   // Next-state and datapath update.
   // opa doubles as the result shift register: each consumed A bit leaves
   // the LSB while the matching sum bit enters at the MSB, so after WIDTH
   // shifts it holds the complete sum.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cmsb_d  = cmsb_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               opa_d   = A;
               opb_d   = Sub ? ~B : B;
               carry_d = Sub ? 1'b1 : Cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            opa_d   = {cell_s, opa_q[WIDTH-1:1]};
            opb_d   = {1'b0, opb_q[WIDTH-1:1]};
            carry_d = cell_co;
            // Carry out of bit WIDTH-2 is the carry into the MSB.
            if (cnt_q == CNT_PEN) begin
               cmsb_d = cell_co;
            end
            if (cnt_q == CNT_LAST) begin
               sum_d   = {cell_s, opa_q[WIDTH-1:1]};
               cout_d  = cell_co;
               ovf_d   = cmsb_q ^ cell_co;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // State and output registers; reset overrides any pending request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cmsb_q  <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cmsb_q  <= cmsb_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Sum  = sum_q;
   assign Cout = cout_q;
   assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl (WIDTH=8) with hand-computed results.
module tb_serial_adder_ctrl;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_vec;
   int n_err;

   // Last result the bench expects Sum/Cout/Ovf to hold.
   logic [W-1:0] prev_sum;
   logic         prev_cout;
   logic         prev_ovf;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .Sub   (sub),
      .A     (a),
      .B     (b),
      .Cin   (cin),
      .busy  (busy),
      .done  (done),
      .Sum   (sum),
      .Cout  (cout),
      .Ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full operation: start, WIDTH busy cycles, one done cycle, then idle.
   task automatic run_op(input string tag, input logic [W-1:0] opa, input logic [W-1:0] opb,
                         input logic s, input logic ci, input logic [W-1:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf, input logic disturb);
      a = opa; b = opb; sub = s; cin = ci; start = 1'b1;
      step();
      start = 1'b0;
      // Scramble the operand inputs; the latched copy must be used.
      a = ~opa; b = ~opb; sub = ~s; cin = ~ci;
      for (int k = 1; k <= 8; k++) begin
         check({tag, " busy"}, 32'(busy), 32'd1);
         check({tag, " done_low"}, 32'(done), 32'd0);
         check({tag, " sum_hold"}, 32'(sum), 32'(prev_sum));
         if (disturb && k == 3) begin
            start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b1; cin = 1'b1;
         end else if (disturb && k == 4) begin
            start = 1'b0; a = 8'hFF; b = 8'h00;
         end
         step();
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy_low"}, 32'(busy), 32'd0);
      check({tag, " sum"}, 32'(sum), 32'(exp_sum));
      check({tag, " cout"}, 32'(cout), 32'(exp_cout));
      check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
      step();
      check({tag, " done_pulse"}, 32'(done), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
      check({tag, " sum_keep"}, 32'(sum), 32'(exp_sum));
      prev_sum = exp_sum; prev_cout = exp_cout; prev_ovf = exp_ovf;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

      // Reset state.
      step(); step();
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst sum", 32'(sum), 32'd0);
      check("rst cout", 32'(cout), 32'd0);
      check("rst ovf", 32'(ovf), 32'd0);

      // start together with rst is dropped.
      start = 1'b1; a = 8'h12; b = 8'h34;
      step();
      rst = 1'b0; start = 1'b0;
      step();
      check("rst_start busy", 32'(busy), 32'd0);
      step();
      check("rst_start done", 32'(done), 32'd0);

      // Basic add/subtract vectors.
      run_op("add3c5a", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
      run_op("addff01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      run_op("add1020c", 8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
      run_op("sub0507", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
      run_op("sub8001", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);

      // Second request mid-operation is ignored.
      run_op("ignore", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);

      // Make the previous result distinctive before the abort test.
      run_op("sub8001b", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);

      // Abort in the 4th RUN cycle.
      a = 8'h3C; b = 8'h5A; sub = 1'b0; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      check("abort busy_run", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort sum", 32'(sum), 32'd0);
      check("abort cout", 32'(cout), 32'd0);
      check("abort ovf", 32'(ovf), 32'd0);
      for (int k = 0; k < 10; k++) begin
         check("abort no_done", 32'(done), 32'd0);
         step();
      end
      prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
      run_op("after_abort", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);

      // Back-to-back with start held high: done every 10 cycles.
      a = 8'h3C; b = 8'h5A; sub = 1'b0; cin = 1'b0; start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 1) begin
            a = 8'h01;
         end else if (k == 11) begin
            a = 8'hC0;
         end
         check("b2b done", 32'(done), (k % 10 == 9) ? 32'd1 : 32'd0);
         check("b2b busy", 32'(busy), (k % 10 == 9 || k % 10 == 0) ? 32'd0 : 32'd1);
         if (k == 9) begin
            check("b2b sum1", 32'(sum), 32'h96);
            check("b2b ovf1", 32'(ovf), 32'd1);
         end else if (k == 19) begin
            check("b2b sum2", 32'(sum), 32'h5B);
            check("b2b cout2", 32'(cout), 32'd0);
         end else if (k == 29) begin
            check("b2b sum3", 32'(sum), 32'h1A);
            check("b2b cout3", 32'(cout), 32'd1);
            check("b2b ovf3", 32'(ovf), 32'd0);
         end
      end
      start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
